// File: rtl/dual_port_mem_pkg.sv
// Shared defaults and FSM encoding for the dual-port data memory.
package mem_pkg;

  localparam int unsigned int_32   = 32;
  localparam int unsigned mem_size = 1024;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/dual_port_mem_if.sv
// Request/response bundle between the load/store address mux and the data memory.
interface dual_port_mem_if
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = int_32,
  parameter int unsigned ADDR_W = int_32
) ();

  logic              req_valid;
  logic [ADDR_W-1:0] add_1;
  logic [ADDR_W-1:0] add_2;
  logic              store_1;
  logic              store_2;
  logic [DATA_W-1:0] store_val_1;
  logic [DATA_W-1:0] store_val_2;
  logic              ready;
  logic [DATA_W-1:0] load_val_1;
  logic [DATA_W-1:0] load_val_2;
  logic              rd_valid_1;
  logic              rd_valid_2;
  logic              collision;
  logic              addr_err;

  modport master (
    output req_valid,
    output add_1,
    output add_2,
    output store_1,
    output store_2,
    output store_val_1,
    output store_val_2,
    input  ready,
    input  load_val_1,
    input  load_val_2,
    input  rd_valid_1,
    input  rd_valid_2,
    input  collision,
    input  addr_err
  );

  modport slave (
    input  req_valid,
    input  add_1,
    input  add_2,
    input  store_1,
    input  store_2,
    input  store_val_1,
    input  store_val_2,
    output ready,
    output load_val_1,
    output load_val_2,
    output rd_valid_1,
    output rd_valid_2,
    output collision,
    output addr_err
  );

endinterface

// File: rtl/dual_port_mem_tdp_ram.sv
// True dual-port RAM: synchronous read-first reads, port 2 wins a same-address write.
module tdp_ram #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MEM_SIZE = 1024,
  localparam int unsigned IDX_W   = $clog2(MEM_SIZE)
) (
  input  logic              clk,
  input  logic              we_1,
  input  logic              re_1,
  input  logic [IDX_W-1:0]  addr_1,
  input  logic [DATA_W-1:0] wdata_1,
  output logic [DATA_W-1:0] rdata_1,
  input  logic              we_2,
  input  logic              re_2,
  input  logic [IDX_W-1:0]  addr_2,
  input  logic [DATA_W-1:0] wdata_2,
  output logic [DATA_W-1:0] rdata_2
);

  logic [DATA_W-1:0] mem [MEM_SIZE];
  logic              we_1_eff;

  // Drop the port 1 write outright on a same-address clash so ordering never matters.
  assign we_1_eff = we_1 && !(we_2 && (addr_1 == addr_2));

  always_ff @(posedge clk) begin
    if (re_1) begin
      rdata_1 <= mem[addr_1];
    end
    if (re_2) begin
      rdata_2 <= mem[addr_2];
    end
    if (we_1_eff) begin
      mem[addr_1] <= wdata_1;
    end
    if (we_2) begin
      mem[addr_2] <= wdata_2;
    end
  end

endmodule

// File: rtl/dual_port_mem.sv
// Two-op-per-cycle data memory: zero-fills after reset, then serves loads/stores with range
// checking, collision detection and a one-cycle load response.
module dual_port_mem
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W   = int_32,
  parameter int unsigned ADDR_W   = int_32,
  parameter int unsigned MEM_SIZE = mem_size
) (
  input  logic             clk,
  input  logic             rst_n,
  dual_port_mem_if.slave   bus
);

  localparam int unsigned       IDX_W    = $clog2(MEM_SIZE);
  localparam int unsigned       CNT_W    = IDX_W + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MEM_SIZE - 1);
  localparam logic [ADDR_W-1:0] ADDR_LIM = ADDR_W'(MEM_SIZE);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clear_we;

  logic ready;
  logic acc;
  logic in_rng_1, in_rng_2;
  logic load_1, load_2;

  logic              ram_we_1, ram_re_1, ram_we_2, ram_re_2;
  logic [IDX_W-1:0]  ram_addr_1, ram_addr_2;
  logic [DATA_W-1:0] ram_wdata_1, ram_rdata_1, ram_rdata_2;

  logic rd_valid_1_q, rd_valid_2_q;
  logic zero_1_q, zero_2_q;
  logic collision_q, addr_err_q;

  // ---------------------------------------------------------------------------
  // Clear / run sequencing
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clear_we = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clear_we = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  assign ready = (state_q == ST_RUN);

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  // rst_n gates acceptance so an op presented in the reset cycle leaves no trace.
  assign acc      = bus.req_valid && ready && rst_n;
  assign in_rng_1 = (bus.add_1 < ADDR_LIM);
  assign in_rng_2 = (bus.add_2 < ADDR_LIM);
  assign load_1   = acc && !bus.store_1;
  assign load_2   = acc && !bus.store_2;

  // Port 1 is borrowed by the zero-fill while clearing; no request is accepted then.
  assign ram_we_1    = clear_we || (acc && bus.store_1 && in_rng_1);
  assign ram_addr_1  = clear_we ? cnt_q[IDX_W-1:0] : bus.add_1[IDX_W-1:0];
  assign ram_wdata_1 = clear_we ? '0 : bus.store_val_1;
  assign ram_re_1    = load_1 && in_rng_1;

  assign ram_we_2   = acc && bus.store_2 && in_rng_2;
  assign ram_addr_2 = bus.add_2[IDX_W-1:0];
  assign ram_re_2   = load_2 && in_rng_2;

  tdp_ram #(
    .DATA_W   (DATA_W),
    .MEM_SIZE (MEM_SIZE)
  ) u_ram (
    .clk     (clk),
    .we_1    (ram_we_1),
    .re_1    (ram_re_1),
    .addr_1  (ram_addr_1),
    .wdata_1 (ram_wdata_1),
    .rdata_1 (ram_rdata_1),
    .we_2    (ram_we_2),
    .re_2    (ram_re_2),
    .addr_2  (ram_addr_2),
    .wdata_2 (bus.store_val_2),
    .rdata_2 (ram_rdata_2)
  );

  // ---------------------------------------------------------------------------
  // Response pipeline
  // ---------------------------------------------------------------------------
  // zero_x_q masks the RAM read register: set by reset or an out-of-range load, cleared by
  // an in-range load, so load_val_x holds its last value between loads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid_1_q <= 1'b0;
      rd_valid_2_q <= 1'b0;
      zero_1_q     <= 1'b1;
      zero_2_q     <= 1'b1;
      collision_q  <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      rd_valid_1_q <= load_1;
      rd_valid_2_q <= load_2;
      if (load_1) begin
        zero_1_q <= !in_rng_1;
      end
      if (load_2) begin
        zero_2_q <= !in_rng_2;
      end
      collision_q <= acc && bus.store_1 && bus.store_2 && in_rng_1 && in_rng_2 &&
                     (bus.add_1 == bus.add_2);
      addr_err_q  <= acc && (!in_rng_1 || !in_rng_2);
    end
  end

  assign bus.ready      = ready;
  assign bus.load_val_1 = zero_1_q ? '0 : ram_rdata_1;
  assign bus.load_val_2 = zero_2_q ? '0 : ram_rdata_2;
  assign bus.rd_valid_1 = rd_valid_1_q;
  assign bus.rd_valid_2 = rd_valid_2_q;
  assign bus.collision  = collision_q;
  assign bus.addr_err   = addr_err_q;

endmodule

// File: tb/tb_dual_port_mem.sv
// Randomized bench for dual_port_mem against an array-based model of the memory contract.
module tb_dual_port_mem;

  localparam int unsigned MemSize = 1024;

  logic clk;
  logic rst_n;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mm [MemSize];
  logic [31:0] e_lv1, e_lv2;

  dual_port_mem_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  dual_port_mem #(
    .DATA_W   (32),
    .ADDR_W   (32),
    .MEM_SIZE (MemSize)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(MemSize); i++) mm[i] = 32'h0;
    e_lv1 = 32'h0;
    e_lv2 = 32'h0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 32'(bus.ready), 32'h0);
    check({tag, "_lv1"}, bus.load_val_1, 32'h0);
    check({tag, "_lv2"}, bus.load_val_2, 32'h0);
    check({tag, "_rv1"}, 32'(bus.rd_valid_1), 32'h0);
    check({tag, "_rv2"}, 32'(bus.rd_valid_2), 32'h0);
    check({tag, "_col"}, 32'(bus.collision), 32'h0);
    check({tag, "_err"}, 32'(bus.addr_err), 32'h0);
  endtask

  // Counts negedge samples with ready low from the release point; optionally presents
  // requests the whole time, which must all be ignored.
  task automatic wait_clear(output int n, input bit poke);
    int seen = 0;
    if (poke) begin
      bus.req_valid   = 1'b1;
      bus.store_1     = 1'b1;
      bus.add_1       = 32'd0;
      bus.store_val_1 = 32'hFFFF_FFFF;
      bus.store_2     = 1'b0;
      bus.add_2       = 32'd1;
    end
    n = 0;
    while (bus.ready !== 1'b1 && n < 5000) begin
      if (bus.rd_valid_1 || bus.rd_valid_2 || bus.collision || bus.addr_err) seen++;
      n++;
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    if (poke) check("clear_quiet", 32'(seen), 32'h0);
  endtask

  // One cycle in RUN: drive at a negedge, predict, check at the following negedge.
  task automatic run_op(input logic v,
                        input logic [31:0] a1, input logic s1, input logic [31:0] d1,
                        input logic [31:0] a2, input logic s2, input logic [31:0] d2);
    logic ok1, ok2, e_rv1, e_rv2, e_col, e_err;
    bus.req_valid   = v;
    bus.add_1       = a1;
    bus.store_1     = s1;
    bus.store_val_1 = d1;
    bus.add_2       = a2;
    bus.store_2     = s2;
    bus.store_val_2 = d2;
    ok1   = (a1 < MemSize);
    ok2   = (a2 < MemSize);
    e_rv1 = v && !s1;
    e_rv2 = v && !s2;
    if (e_rv1) e_lv1 = ok1 ? mm[a1] : 32'h0;
    if (e_rv2) e_lv2 = ok2 ? mm[a2] : 32'h0;
    e_col = v && s1 && s2 && ok1 && ok2 && (a1 == a2);
    e_err = v && (!ok1 || !ok2);
    if (v && s1 && ok1) mm[a1] = d1;
    if (v && s2 && ok2) mm[a2] = d2;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("ready", 32'(bus.ready), 32'h1);
    check("rd_valid_1", 32'(bus.rd_valid_1), 32'(e_rv1));
    check("rd_valid_2", 32'(bus.rd_valid_2), 32'(e_rv2));
    check("load_val_1", bus.load_val_1, e_lv1);
    check("load_val_2", bus.load_val_2, e_lv2);
    check("collision", 32'(bus.collision), 32'(e_col));
    check("addr_err", 32'(bus.addr_err), 32'(e_err));
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r = $urandom_range(19, 0);
    if (r == 0) return $urandom_range(32'hFFFF_FFFF, MemSize);
    if (r < 4) return $urandom_range(MemSize - 1, 0);
    return $urandom_range(15, 0);
  endfunction

  initial begin
    int n;
    rst_n           = 1'b0;
    bus.req_valid   = 1'b0;
    bus.add_1       = '0;
    bus.add_2       = '0;
    bus.store_1     = 1'b0;
    bus.store_2     = 1'b0;
    bus.store_val_1 = '0;
    bus.store_val_2 = '0;
    model_reset();

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");

    // Clear length, with ignored traffic aimed at an already-cleared word.
    rst_n = 1'b1;
    wait_clear(n, 1'b1);
    check("clear_len", 32'(n), 32'd1024);

    run_op(1'b1, 32'd0, 1'b0, 32'h0, 32'd511, 1'b0, 32'h0);
    check("zero_0", bus.load_val_1, 32'h0);
    check("zero_511", bus.load_val_2, 32'h0);
    run_op(1'b1, 32'd1023, 1'b0, 32'h0, 32'd1023, 1'b0, 32'h0);
    check("zero_1023", bus.load_val_1, 32'h0);

    // Store then load on the other port.
    run_op(1'b1, 32'd5, 1'b1, 32'hDEAD_BEEF, 32'd100, 1'b0, 32'h0);
    run_op(1'b1, 32'd200, 1'b0, 32'h0, 32'd5, 1'b0, 32'h0);
    check("st_ld", bus.load_val_2, 32'hDEAD_BEEF);

    // Read-first on a same-address store/load pair.
    run_op(1'b1, 32'd7, 1'b1, 32'h11, 32'd300, 1'b0, 32'h0);
    run_op(1'b1, 32'd7, 1'b1, 32'h22, 32'd7, 1'b0, 32'h0);
    check("read_first", bus.load_val_2, 32'h11);
    run_op(1'b1, 32'd7, 1'b0, 32'h0, 32'd8, 1'b0, 32'h0);
    check("read_after", bus.load_val_1, 32'h22);

    // Write collision: port 2 wins.
    run_op(1'b1, 32'd9, 1'b1, 32'hAAAA, 32'd9, 1'b1, 32'hBBBB);
    check("col_pulse", 32'(bus.collision), 32'h1);
    run_op(1'b0, 32'd0, 1'b0, 32'h0, 32'd0, 1'b0, 32'h0);
    run_op(1'b1, 32'd9, 1'b0, 32'h0, 32'd9, 1'b0, 32'h0);
    check("col_win1", bus.load_val_1, 32'hBBBB);
    check("col_win2", bus.load_val_2, 32'hBBBB);

    // Out of range on both ports.
    run_op(1'b1, 32'd1024, 1'b1, 32'h5, 32'd2000, 1'b0, 32'h0);
    check("oor_err", 32'(bus.addr_err), 32'h1);
    check("oor_load", bus.load_val_2, 32'h0);
    run_op(1'b1, 32'd0, 1'b0, 32'h0, 32'd12, 1'b0, 32'h0);
    check("oor_mem0", bus.load_val_1, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      run_op($urandom_range(3, 0) != 0,
             rand_addr(), 1'($urandom_range(1, 0)), $urandom(),
             rand_addr(), 1'($urandom_range(1, 0)), $urandom());
    end

    // Reset during CLEAR at cnt = 300.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (300) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst_clear");
    rst_n = 1'b1;
    wait_clear(n, 1'b0);
    check("reclear_len", 32'(n), 32'd1024);

    // Reset in RUN with a load presented in the reset cycle.
    run_op(1'b1, 32'd5, 1'b1, 32'h1234, 32'd6, 1'b0, 32'h0);
    run_op(1'b1, 32'd5, 1'b0, 32'h0, 32'd5, 1'b0, 32'h0);
    check("pre_rst_lv1", bus.load_val_1, 32'h1234);
    bus.req_valid = 1'b1;
    bus.store_1   = 1'b0;
    bus.store_2   = 1'b0;
    bus.add_1     = 32'd5;
    bus.add_2     = 32'd5;
    rst_n         = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check_idle_outputs("rst_run");
    rst_n = 1'b1;
    model_reset();
    wait_clear(n, 1'b0);
    check("final_clear_len", 32'(n), 32'd1024);
    run_op(1'b1, 32'd5, 1'b0, 32'h0, 32'd6, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
